// File: rtl/idu_issue_queue.sv
// idu_issue_queue: DEPTH-entry in-order instruction queue between IFU and
// decode/EXU. A per-register in-flight writer counter (scoreboard) holds the
// queue head while a source register is pending or the destination counter
// is saturated. Writebacks release counter entries.
module idu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_inst,
  output logic [4:0]              out_rd,
  input  logic                    wb_valid,
  input  logic [4:0]              wb_rd,
  output logic                    raw_stall,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(NREG);

  localparam logic [CW-1:0]    CountFull = CW'(DEPTH);
  localparam logic [CW-1:0]    CountOne  = CW'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);
  localparam logic [CNT_W-1:0] SbOne     = CNT_W'(1);

  localparam logic [4:0] OpcLui    = 5'b01101;
  localparam logic [4:0] OpcAuipc  = 5'b00101;
  localparam logic [4:0] OpcJal    = 5'b11011;
  localparam logic [4:0] OpcBranch = 5'b11000;
  localparam logic [4:0] OpcStore  = 5'b01000;
  localparam logic [4:0] OpcRr     = 5'b01100;

  // Queue storage and control
  logic [XLEN-1:0]  r_pc   [DEPTH];
  logic [31:0]      r_inst [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr, w_rd_ptr_nxt, w_wr_ptr_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;

  // Scoreboard: number of issued, not yet retired writers per register
  logic [CNT_W-1:0] r_sb     [NREG];
  logic [CNT_W-1:0] w_sb_nxt [NREG];

  logic [4:0]       w_opc;
  logic             w_uses_rs1, w_uses_rs2, w_writes;
  logic [IDX_W-1:0] w_rs1_idx, w_rs2_idx, w_rd_idx, w_wb_idx;
  logic             w_hazard, w_not_empty;
  logic             w_enq, w_deq, w_issue_wr, w_wb_dec;

  // Head entry is always presented; only out_valid qualifies it
  assign out_pc   = r_pc[r_rd_ptr];
  assign out_inst = r_inst[r_rd_ptr];

  // Head decode
  assign w_opc      = out_inst[6:2];
  assign w_uses_rs1 = !(w_opc == OpcLui || w_opc == OpcAuipc || w_opc == OpcJal);
  assign w_uses_rs2 = (w_opc == OpcBranch) || (w_opc == OpcStore) || (w_opc == OpcRr);
  assign w_writes   = !(w_opc == OpcBranch || w_opc == OpcStore) && (out_inst[11:7] != 5'd0);
  assign out_rd     = w_writes ? out_inst[11:7] : 5'd0;

  // RV32E keeps only the low index bits
  assign w_rs1_idx = out_inst[15 +: IDX_W];
  assign w_rs2_idx = out_inst[20 +: IDX_W];
  assign w_rd_idx  = out_inst[7 +: IDX_W];
  assign w_wb_idx  = wb_rd[IDX_W-1:0];

  assign w_hazard = (w_uses_rs1 && (w_rs1_idx != '0) && (r_sb[w_rs1_idx] != '0)) ||
                    (w_uses_rs2 && (w_rs2_idx != '0) && (r_sb[w_rs2_idx] != '0)) ||
                    (w_writes && (r_sb[w_rd_idx] == '1));

  assign w_not_empty = (r_count != '0);
  assign in_ready    = (r_count != CountFull);
  assign out_valid   = w_not_empty & ~w_hazard & ~flush;
  assign raw_stall   = w_not_empty & w_hazard & ~flush;
  assign count       = r_count;

  // A flush swallows any incoming instruction; out_valid already excludes flush
  assign w_enq      = in_valid & in_ready & ~flush;
  assign w_deq      = out_valid & out_ready;
  assign w_issue_wr = w_deq & w_writes;
  // Spurious writebacks (x0 or idle counter) must not underflow
  assign w_wb_dec   = wb_valid & (w_wb_idx != '0) & (r_sb[w_wb_idx] != '0);

  // Next-state for pointers and occupancy
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (flush) begin
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_enq) w_wr_ptr_nxt = r_wr_ptr + PtrOne;
      if (w_deq) w_rd_ptr_nxt = r_rd_ptr + PtrOne;
      if (w_enq && !w_deq) begin
        w_count_nxt = r_count + CountOne;
      end else if (!w_enq && w_deq) begin
        w_count_nxt = r_count - CountOne;
      end
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Payload storage; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_pc[r_wr_ptr]   <= in_pc;
      r_inst[r_wr_ptr] <= in_inst;
    end
  end

  // Scoreboard next-state: issue increments, writeback decrements, both cancel
  always_comb begin
    w_sb_nxt = r_sb;
    for (int unsigned i = 1; i < NREG; i++) begin
      if ((w_issue_wr && (w_rd_idx == IDX_W'(i))) &&
          !(w_wb_dec && (w_wb_idx == IDX_W'(i)))) begin
        w_sb_nxt[i] = r_sb[i] + SbOne;
      end else if (!(w_issue_wr && (w_rd_idx == IDX_W'(i))) &&
                   (w_wb_dec && (w_wb_idx == IDX_W'(i)))) begin
        w_sb_nxt[i] = r_sb[i] - SbOne;
      end
    end
    w_sb_nxt[0] = '0;
  end

  // Scoreboard registers; flush deliberately leaves them intact
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sb <= '{default: '0};
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

endmodule

// File: tb/tb_idu_issue_queue.sv
// Self-checking bench for idu_issue_queue: directed scenarios plus a random
// run compared against a queue + per-register counter reference model.
module tb_idu_issue_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int CNT_W = 2;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic            clock = 1'b0;
  logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0] in_pc, out_pc;
  logic [31:0]     in_inst, out_inst;
  logic [4:0]      out_rd, wb_rd;
  logic            wb_valid, raw_stall;
  logic [2:0]      count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t mq[$];
  int     msb[NREG];

  always #5 clock = ~clock;

  idu_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rd(out_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .raw_stall(raw_stall),
    .count(count)
  );

  // ---------------- reference model (instruction-level rules) ----------------
  function automatic bit f_uses_rs1(logic [31:0] inst);
    logic [4:0] o;
    o = inst[6:2];
    return !(o == 5'b01101 || o == 5'b00101 || o == 5'b11011);
  endfunction

  function automatic bit f_uses_rs2(logic [31:0] inst);
    logic [4:0] o;
    o = inst[6:2];
    return (o == 5'b11000 || o == 5'b01000 || o == 5'b01100);
  endfunction

  function automatic bit f_writes(logic [31:0] inst);
    logic [4:0] o;
    o = inst[6:2];
    return !(o == 5'b11000 || o == 5'b01000) && (inst[11:7] != 5'd0);
  endfunction

  function automatic bit m_hazard();
    logic [31:0] inst;
    int rs1, rs2, rd;
    if (mq.size() == 0) return 1'b0;
    inst = mq[0].inst;
    rs1 = int'(inst[19:15]);
    rs2 = int'(inst[24:20]);
    rd  = int'(inst[11:7]);
    return (f_uses_rs1(inst) && rs1 != 0 && msb[rs1] != 0) ||
           (f_uses_rs2(inst) && rs2 != 0 && msb[rs2] != 0) ||
           (f_writes(inst) && msb[rd] == SAT);
  endfunction

  function automatic bit m_out_valid();
    return (mq.size() != 0) && !m_hazard() && !flush;
  endfunction

  function automatic logic [4:0] m_rd();
    if (mq.size() == 0) return 5'd0;
    return f_writes(mq[0].inst) ? mq[0].inst[11:7] : 5'd0;
  endfunction

  // Advance one clock; the model consumes the inputs the DUT sees at this edge
  task automatic tick();
    bit deq, enq, dec;
    int ird, wr;
    entry_t e;
    @(posedge clock);
    if (!reset) begin
      mq.delete();
      foreach (msb[i]) msb[i] = 0;
    end else begin
      deq = m_out_valid() && out_ready;
      enq = in_valid && (mq.size() != DEPTH) && !flush;
      ird = 0;
      if (deq && f_writes(mq[0].inst)) ird = int'(mq[0].inst[11:7]);
      wr  = int'(wb_rd);
      dec = wb_valid && wr != 0 && msb[wr] != 0;
      if (deq) void'(mq.pop_front());
      if (enq) begin
        e.pc = in_pc;
        e.inst = in_inst;
        mq.push_back(e);
      end
      if (flush) mq.delete();
      if (ird != 0) msb[ird] = msb[ird] + 1;
      if (dec) msb[wr] = msb[wr] - 1;
    end
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc_addi(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(int rd, int rs1, int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [9];
    logic [31:0] inst;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011, 7'b0100011,
            7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111};
    inst = $urandom;
    inst[6:0]   = ops[$urandom_range(0, 8)];
    inst[11:7]  = 5'($urandom_range(0, 7));
    inst[19:15] = 5'($urandom_range(0, 7));
    inst[24:20] = 5'($urandom_range(0, 7));
    return inst;
  endfunction

  task automatic set_idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; in_pc = '0; in_inst = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic push(logic [31:0] pc, logic [31:0] inst);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    push(32'h1234, enc_addi(1, 0, 1));
    tick();
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (raw_stall !== 1'b0) begin n_fail++; $display("FAIL reset_raw_stall: got %b expected 0", raw_stall); end
    tick();
    // Mid-operation reset must also clear a pending writer
    out_ready = 1'b1;
    push(32'h40, enc_addi(5, 0, 1));
    tick();
    push(32'h44, enc_add(6, 5, 5));
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL midreset_count: got %0d expected 0", count); end
    tick();
    push(32'h48, enc_add(6, 5, 5));
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_sb_clear: out_valid got %b expected 1", out_valid); end
    tick();
  endtask

  task automatic test_fill();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h80000000 + 32'(4 * i), enc_addi(10 + i, 0, i));
      tick();
    end
    in_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    tick();
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      @(negedge clock);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h80000000 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: got valid=%b pc=%h expected valid=1 pc=%h",
                 i, out_valid, out_pc, 32'h80000000 + 32'(4 * i));
      end
      tick();
    end
    out_ready = 1'b0;
    @(negedge clock);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fill_drained: got %0d expected 0", count); end
    tick();
  endtask

  task automatic test_raw();
    do_reset();
    out_ready = 1'b1;
    push(32'h100, enc_addi(5, 0, 1));
    tick();
    push(32'h104, enc_add(6, 5, 5));
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1 || out_rd !== 5'd5) begin n_fail++; $display("FAIL raw_first_issue: got valid=%b rd=%0d expected 1/5", out_valid, out_rd); end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++; if (raw_stall !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall[%0d]: got stall=%b valid=%b expected 1/0", i, raw_stall, out_valid); end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd5;
    @(negedge clock);
    n_checks++; if (raw_stall !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle: got stall=%b expected 1", raw_stall); end
    tick();
    wb_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1 || out_rd !== 5'd6 || raw_stall !== 1'b0) begin n_fail++; $display("FAIL raw_release: got valid=%b rd=%0d stall=%b expected 1/6/0", out_valid, out_rd, raw_stall); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(32'h200 + 32'(4 * k), enc_addi(7, 0, k));
      if (k > 0) begin
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_issue[%0d]: got valid=%b expected 1", k, out_valid); end
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_checks++; if (raw_stall !== 1'b1 || out_valid !== 1'b0 || out_pc !== 32'h20C) begin n_fail++; $display("FAIL sat_stall[%0d]: got stall=%b valid=%b pc=%h expected 1/0/20c", i, raw_stall, out_valid, out_pc); end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd7;
    @(negedge clock);
    n_checks++; if (raw_stall !== 1'b1) begin n_fail++; $display("FAIL sat_wb_cycle: got stall=%b expected 1", raw_stall); end
    tick();
    wb_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20C) begin n_fail++; $display("FAIL sat_release: got valid=%b pc=%h expected 1/20c", out_valid, out_pc); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    out_ready = 1'b1;
    push(32'h300, enc_addi(8, 0, 1));
    tick();
    push(32'h304, enc_addi(8, 0, 2));
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL simul_first: got valid=%b expected 1", out_valid); end
    tick();
    push(32'h308, enc_add(9, 8, 0));
    wb_valid = 1'b1; wb_rd = 5'd8;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304) begin n_fail++; $display("FAIL simul_issue_wb: got valid=%b pc=%h expected 1/304", out_valid, out_pc); end
    tick();
    in_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (raw_stall !== 1'b1 || out_pc !== 32'h308) begin n_fail++; $display("FAIL simul_net_one: got stall=%b pc=%h expected 1/308", raw_stall, out_pc); end
    tick();
    wb_valid = 1'b1; wb_rd = 5'd8;
    @(negedge clock);
    n_checks++; if (raw_stall !== 1'b1) begin n_fail++; $display("FAIL simul_wb_cycle: got stall=%b expected 1", raw_stall); end
    tick();
    wb_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL simul_release: got valid=%b expected 1", out_valid); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    push(32'h400, enc_addi(3, 0, 1));
    tick();
    push(32'h404, enc_add(4, 3, 0));
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_writer_issue: got valid=%b expected 1", out_valid); end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'h408 + 32'(4 * i), enc_addi(0, 0, i));
      tick();
    end
    push(32'h414, enc_addi(1, 0, 1));
    flush = 1'b1; out_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd0;
    @(negedge clock);
    n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_full: got count=%0d in_ready=%b expected 4/0", count, in_ready); end
    n_checks++; if (out_valid !== 1'b0 || raw_stall !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_outs: got valid=%b stall=%b expected 0/0", out_valid, raw_stall); end
    tick();
    set_idle();
    @(negedge clock);
    n_checks++; if (count !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got count=%0d in_ready=%b expected 0/1", count, in_ready); end
    tick();
    push(32'h500, enc_add(4, 3, 0));
    wb_valid = 1'b1; wb_rd = 5'd9;
    tick();
    push(32'h504, enc_add(10, 9, 9));
    wb_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (raw_stall !== 1'b1 || out_pc !== 32'h500) begin n_fail++; $display("FAIL flush_sb_kept: got stall=%b pc=%h expected 1/500", raw_stall, out_pc); end
    tick();
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3; out_ready = 1'b1;
    @(negedge clock);
    n_checks++; if (raw_stall !== 1'b1) begin n_fail++; $display("FAIL flush_wb_cycle: got stall=%b expected 1", raw_stall); end
    tick();
    wb_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h500) begin n_fail++; $display("FAIL flush_release: got valid=%b pc=%h expected 1/500", out_valid, out_pc); end
    tick();
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h504) begin n_fail++; $display("FAIL spurious_wb_no_underflow: got valid=%b pc=%h expected 1/504", out_valid, out_pc); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      in_valid = (i < 10);
      in_pc = 32'h600 + 32'(4 * i);
      in_inst = enc_addi(0, 0, i);
      @(negedge clock);
      n_checks++; if (count > 3'd1) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected <=1", i, count); end
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h600 + 32'(4 * (i - 1))) begin
          n_fail++;
          $display("FAIL wrap_order[%0d]: got valid=%b pc=%h expected 1/%h",
                   i, out_valid, out_pc, 32'h600 + 32'(4 * (i - 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int pend[$];
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_inst   = rand_inst();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      pend.delete();
      for (int k = 1; k < NREG; k++) if (msb[k] != 0) pend.push_back(k);
      wb_valid = 1'b0; wb_rd = 5'd0;
      if (pend.size() != 0 && $urandom_range(0, 2) == 0) begin
        wb_valid = 1'b1;
        wb_rd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
      end else if ($urandom_range(0, 15) == 0) begin
        // Spurious writeback: x0, or an idle register that the head will not write
        r = $urandom_range(0, 15);
        if (r != 0 && (msb[r] != 0 || r == int'(m_rd()))) r = 0;
        wb_valid = 1'b1;
        wb_rd = 5'(r);
      end
      @(negedge clock);
      n_checks++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", c, count, mq.size()); end
      n_checks++; if (in_ready !== (mq.size() != DEPTH)) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, in_ready, mq.size() != DEPTH); end
      n_checks++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", c, out_valid, m_out_valid()); end
      n_checks++;
      if (raw_stall !== ((mq.size() != 0) && m_hazard() && !flush)) begin
        n_fail++;
        $display("FAIL rand_raw_stall[%0d]: got %b expected %b", c, raw_stall,
                 (mq.size() != 0) && m_hazard() && !flush);
      end
      if (mq.size() != 0) begin
        n_checks++;
        if (out_pc !== mq[0].pc || out_inst !== mq[0].inst || out_rd !== m_rd()) begin
          n_fail++;
          $display("FAIL rand_head[%0d]: got pc=%h inst=%h rd=%0d expected pc=%h inst=%h rd=%0d",
                   c, out_pc, out_inst, out_rd, mq[0].pc, mq[0].inst, m_rd());
        end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_raw();
    test_saturation();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
